// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory BIST engine: FSM state codes, data
// pattern selectors and the LFSR generator used for the pseudo-random pattern.
package mem_bist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_WR     = 4'd1,
        ST_WR_GAP = 4'd2,
        ST_RD     = 4'd3,
        ST_RD_GAP = 4'd4,
        ST_DONE   = 4'd5
    } state_t;

    localparam logic [1:0] MODE_ADDR  = 2'd0;
    localparam logic [1:0] MODE_NADDR = 2'd1;
    localparam logic [1:0] MODE_WALK  = 2'd2;
    localparam logic [1:0] MODE_LFSR  = 2'd3;

    localparam logic [31:0] LFSR_SEED = 32'hACE1_2345;
    // Right-shifting Galois toggle mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        return cur[0] ? ({1'b0, cur[31:1]} ^ LFSR_TAPS) : {1'b0, cur[31:1]};
    endfunction

endpackage

// File: rtl/mem_bist_pattern.sv
// Expected-data generator. A single instance feeds both the write data and
// the read-back comparison, so the LFSR is re-seeded between the two passes.
module mem_bist_pattern
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] index,
    input  logic                  load_seed,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] expected
);

    logic [31:0]           lfsr_r;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [ADDR_WIDTH-1:0] shift_s;
    logic [DATA_WIDTH-1:0] one_s;

    // LFSR state: seeded at start of each pass, stepped once per element
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lfsr_r <= LFSR_SEED;
        end else if (load_seed) begin
            lfsr_r <= LFSR_SEED;
        end else if (advance) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign addr_s  = base + index;
    assign shift_s = index % ADDR_WIDTH'(DATA_WIDTH);
    assign one_s   = DATA_WIDTH'(1'b1);

    // Pattern select
    always_comb begin
        expected = '0;
        case (mode)
            MODE_ADDR:  expected = DATA_WIDTH'(addr_s);
            MODE_NADDR: expected = ~DATA_WIDTH'(addr_s);
            MODE_WALK:  expected = one_s << shift_s;
            MODE_LFSR:  expected = lfsr_r[DATA_WIDTH-1:0];
            default:    expected = '0;
        endcase
    end

endmodule

// File: rtl/mem_bist.sv
// Memory BIST engine: writes a pattern over [base, base+count) through a
// request/ack port, reads it back, counts mismatches and captures the first.
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic                  sweep_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] count_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  we_o,
    output logic                  rd_o,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ERR_WIDTH-1:0]  err_count_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic [DATA_WIDTH-1:0] err_data_o,
    output logic [15:0]           state_o
);

    state_t                state_r, state_n;
    logic [1:0]            mode_r, mode_n;
    logic                  sweep_r, sweep_n;
    logic [ADDR_WIDTH-1:0] base_r, base_n;
    logic [ADDR_WIDTH-1:0] count_r, count_n;
    logic [ADDR_WIDTH-1:0] index_r, index_n;
    logic [ERR_WIDTH-1:0]  err_count_r, err_count_n;
    logic [ADDR_WIDTH-1:0] err_addr_r, err_addr_n;
    logic [DATA_WIDTH-1:0] err_data_r, err_data_n;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  we_r, rd_r, busy_r, done_r, pass_r;
    logic                  load_seed_s, advance_s, last_s;
    logic [DATA_WIDTH-1:0] expected_s;

    mem_bist_pattern #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pattern (
        .clk       (clk),
        .rstn      (rstn),
        .mode      (mode_r),
        .base      (base_r),
        .index     (index_r),
        .load_seed (load_seed_s),
        .advance   (advance_s),
        .expected  (expected_s)
    );

    assign last_s = (index_r == (count_r - ADDR_WIDTH'(1'b1)));

    // Next-state, index sequencing and error accounting
    always_comb begin
        state_n     = state_r;
        mode_n      = mode_r;
        sweep_n     = sweep_r;
        base_n      = base_r;
        count_n     = count_r;
        index_n     = index_r;
        err_count_n = err_count_r;
        err_addr_n  = err_addr_r;
        err_data_n  = err_data_r;
        load_seed_s = 1'b0;
        advance_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    mode_n      = mode_i;
                    sweep_n     = sweep_i;
                    base_n      = base_i;
                    count_n     = count_i;
                    index_n     = '0;
                    err_count_n = '0;
                    err_addr_n  = '0;
                    err_data_n  = '0;
                    load_seed_s = 1'b1;
                    state_n     = (count_i == '0) ? ST_DONE : ST_WR;
                end else begin
                    state_n = state_r;
                end
            end
            ST_WR: begin
                if (ack_i) begin
                    state_n = ST_WR_GAP;
                end else begin
                    state_n = ST_WR;
                end
            end
            ST_WR_GAP: begin
                if (!sweep_r) begin
                    state_n = ST_RD;
                end else if (last_s) begin
                    // Second pass replays the same sequence from the seed
                    state_n     = ST_RD;
                    index_n     = '0;
                    load_seed_s = 1'b1;
                end else begin
                    state_n   = ST_WR;
                    index_n   = index_r + ADDR_WIDTH'(1'b1);
                    advance_s = 1'b1;
                end
            end
            ST_RD: begin
                if (ack_i) begin
                    state_n = ST_RD_GAP;
                    if (data_i != expected_s) begin
                        if (err_count_r == '0) begin
                            err_addr_n = base_r + index_r;
                            err_data_n = data_i;
                        end else begin
                            err_addr_n = err_addr_r;
                        end
                        if (err_count_r != '1) begin
                            err_count_n = err_count_r + ERR_WIDTH'(1'b1);
                        end else begin
                            err_count_n = err_count_r;
                        end
                    end else begin
                        err_count_n = err_count_r;
                    end
                end else begin
                    state_n = ST_RD;
                end
            end
            ST_RD_GAP: begin
                if (last_s) begin
                    state_n = ST_DONE;
                end else begin
                    index_n   = index_r + ADDR_WIDTH'(1'b1);
                    advance_s = 1'b1;
                    state_n   = sweep_r ? ST_RD : ST_WR;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, configuration and registered status/request outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            mode_r      <= 2'd0;
            sweep_r     <= 1'b0;
            base_r      <= '0;
            count_r     <= '0;
            index_r     <= '0;
            err_count_r <= '0;
            err_addr_r  <= '0;
            err_data_r  <= '0;
            addr_r      <= '0;
            we_r        <= 1'b0;
            rd_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            mode_r      <= mode_n;
            sweep_r     <= sweep_n;
            base_r      <= base_n;
            count_r     <= count_n;
            index_r     <= index_n;
            err_count_r <= err_count_n;
            err_addr_r  <= err_addr_n;
            err_data_r  <= err_data_n;
            addr_r      <= base_n + index_n;
            we_r        <= (state_n == ST_WR);
            rd_r        <= (state_n == ST_RD);
            busy_r      <= (state_n != ST_IDLE) && (state_n != ST_DONE);
            done_r      <= (state_n == ST_DONE);
            pass_r      <= (state_n == ST_DONE) && (err_count_n == '0);
        end
    end

    assign addr_o      = addr_r;
    assign data_o      = expected_s;
    assign we_o        = we_r;
    assign rd_o        = rd_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign pass_o      = pass_r;
    assign err_count_o = err_count_r;
    assign err_addr_o  = err_addr_r;
    assign err_data_o  = err_data_r;
    assign state_o     = {state_r, index_r[11:0]};

endmodule

// File: tb/tb_mem_bist.sv
// Self-checking bench for mem_bist: a latency-configurable memory responder
// with fault injection, and a reference model of the expected transaction stream.
module tb_mem_bist;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_i;
    logic [1:0]  mode_i;
    logic        sweep_i;
    logic [31:0] base_i, count_i, addr_o, data_o, data_i, err_addr_o, err_data_o;
    logic        we_o, rd_o, ack_i, busy_o, done_o, pass_o;
    logic [1:0]  err_count_o;
    logic [15:0] state_o;

    int total = 0;
    int bad   = 0;

    // responder configuration (written only by the main sequence)
    int          lat = 0;
    bit          fault_en = 1'b0;
    bit          zero_mode = 1'b0;
    logic [31:0] fault_addr = 32'h0;
    logic [31:0] fault_mask = 32'h0;
    bit          force_ack = 1'b0;

    // responder state (written only by the responder)
    bit          resp_ack = 1'b0;
    logic [31:0] resp_data = 32'h0;
    logic [31:0] mem [logic [31:0]];
    int          wait_cnt = 0;
    int          rd_starts = 0;
    bit          overlap_seen = 1'b0;
    bit          unstable_seen = 1'b0;
    logic [31:0] held_addr, held_data;
    bit          log_we[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    assign ack_i  = resp_ack | force_ack;
    assign data_i = resp_data;

    always #5 clk = ~clk;

    mem_bist #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_WIDTH(2)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .mode_i(mode_i), .sweep_i(sweep_i),
        .base_i(base_i), .count_i(count_i), .addr_o(addr_o), .data_o(data_o),
        .data_i(data_i), .we_o(we_o), .rd_o(rd_o), .ack_i(ack_i), .busy_o(busy_o),
        .done_o(done_o), .pass_o(pass_o), .err_count_o(err_count_o),
        .err_addr_o(err_addr_o), .err_data_o(err_data_o), .state_o(state_o)
    );

    // Memory model: acks after `lat` wait cycles, stores writes, returns reads
    always @(negedge clk) begin
        logic [31:0] d;
        resp_ack = 1'b0;
        if (we_o === 1'b1 && rd_o === 1'b1) overlap_seen = 1'b1;
        if (rstn === 1'b1 && (we_o === 1'b1 || rd_o === 1'b1)) begin
            if (wait_cnt > 0 && (addr_o !== held_addr || (we_o && data_o !== held_data)))
                unstable_seen = 1'b1;
            held_addr = addr_o;
            held_data = data_o;
            if (rd_o && wait_cnt == 0) rd_starts++;
            if (wait_cnt >= lat) begin
                resp_ack = 1'b1;
                if (we_o) begin
                    mem[addr_o] = data_o;
                end else begin
                    d = mem.exists(addr_o) ? mem[addr_o] : 32'h0;
                    if (zero_mode) d = 32'h0;
                    else if (fault_en && addr_o == fault_addr) d = d ^ fault_mask;
                    resp_data = d;
                end
                log_we.push_back(we_o);
                log_addr.push_back(addr_o);
                log_data.push_back(data_o);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pattern for element i, straight from the pattern definitions
    function automatic logic [31:0] ref_pat(input logic [1:0] m, input logic [31:0] b, input int i);
        logic [31:0] v;
        case (m)
            2'd0: v = b + i;
            2'd1: v = ~(b + i);
            2'd2: v = 32'd1 << (i % 32);
            default: begin
                v = 32'hACE1_2345;
                for (int k = 0; k < i; k++)
                    v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
            end
        endcase
        return v;
    endfunction

    task automatic run_test(input string tag, input logic [1:0] m, input logic sw,
                            input logic [31:0] b, input logic [31:0] cnt, input int l,
                            input bit fe, input logic [31:0] fa, input logic [31:0] fm,
                            input bit zm, input bit poke);
        int n, budget, base_idx, nerr, i, ntr;
        bit wr;
        logic [31:0] ea, ret, exp_pat, first_addr, first_data;
        lat = l; fault_en = fe; fault_addr = fa; fault_mask = fm; zero_mode = zm;
        base_idx = log_addr.size();
        @(negedge clk);
        mode_i = m; sweep_i = sw; base_i = b; count_i = cnt; start_i = 1'b1;
        @(posedge clk); #1;
        n = 0;
        budget = 2 * int'(cnt) * (l + 2) + 20;
        while (!done_o && n < budget) begin
            @(negedge clk);
            if (poke && n == 3) begin
                start_i = 1'b1; mode_i = m ^ 2'd1; count_i = 32'd1; base_i = b + 32'd7;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start_i = 1'b0;
        chk($sformatf("%s.done", tag), done_o, 1'b1);
        if (l == 0) chk($sformatf("%s.cycles", tag), n, 4 * cnt);
        ntr = log_addr.size() - base_idx;
        chk($sformatf("%s.ntrans", tag), ntr, 2 * cnt);
        nerr = 0; first_addr = 32'h0; first_data = 32'h0;
        for (int k = 0; k < 2 * int'(cnt) && k < ntr; k++) begin
            if (!sw) begin i = k / 2; wr = (k % 2 == 0); end
            else begin i = (k < int'(cnt)) ? k : k - int'(cnt); wr = (k < int'(cnt)); end
            ea = b + i;
            exp_pat = ref_pat(m, b, i);
            chk($sformatf("%s.we[%0d]", tag, k), log_we[base_idx + k], wr);
            chk($sformatf("%s.addr[%0d]", tag, k), log_addr[base_idx + k], ea);
            if (wr) begin
                chk($sformatf("%s.wdata[%0d]", tag, k), log_data[base_idx + k], exp_pat);
            end else begin
                ret = zm ? 32'h0 : (exp_pat ^ ((fe && ea == fa) ? fm : 32'h0));
                if (ret != exp_pat) begin
                    if (nerr == 0) begin first_addr = ea; first_data = ret; end
                    nerr++;
                end
            end
        end
        chk($sformatf("%s.err_count", tag), err_count_o, (nerr > 3) ? 3 : nerr);
        chk($sformatf("%s.pass", tag), pass_o, (nerr == 0));
        chk($sformatf("%s.err_addr", tag), err_addr_o, first_addr);
        chk($sformatf("%s.err_data", tag), err_data_o, first_data);
        chk($sformatf("%s.busy", tag), busy_o, 1'b0);
        chk($sformatf("%s.req", tag), {we_o, rd_o}, 2'b00);
    endtask

    initial begin
        int n, rs;
        logic [31:0] rb, rc;
        rstn = 1'b0; start_i = 1'b0; mode_i = 2'd0; sweep_i = 1'b0;
        base_i = 32'h0; count_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.outs", {we_o, rd_o, busy_o, done_o, pass_o, err_count_o}, 7'd0);
        chk("rst.addr", addr_o, 32'h0);
        chk("rst.err", {err_addr_o, err_data_o}, 64'h0);
        chk("rst.state", state_o, 16'h0);
        @(negedge clk); rstn = 1'b1;

        run_test("addr_il",    2'd0, 1'b0, 32'h100,       32'd4,  0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        run_test("lfsr_2p",    2'd3, 1'b1, 32'h2000,      32'd8,  3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        run_test("walk_fault", 2'd2, 1'b0, 32'h0,         32'd16, 1, 1'b1, 32'h5, 32'h1, 1'b0, 1'b0);
        chk("walk_fault.abs_addr", err_addr_o, 32'h5);
        chk("walk_fault.abs_data", err_data_o, 32'h21);
        run_test("sat_wrap",   2'd2, 1'b0, 32'hFFFF_FFFE, 32'd4,  0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("sat_wrap.abs_cnt", err_count_o, 2'd3);
        run_test("naddr_2p",   2'd1, 1'b1, 32'hFFFF_FFFD, 32'd5,  2, 1'b1, 32'h1, 32'h8000_0000, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rb = (r % 2 == 0) ? $urandom : (32'hFFFF_FFF8 + $urandom_range(0, 7));
            rc = $urandom_range(1, 10);
            run_test($sformatf("rnd%0d", r), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     rb, rc, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     rb + $urandom_range(0, rc - 1), 32'd1 << $urandom_range(0, 31), 1'b0, 1'b0);
        end

        // Reset during the second read with its ack still outstanding
        lat = 6; fault_en = 1'b0; zero_mode = 1'b0;
        rs = rd_starts;
        @(negedge clk);
        mode_i = 2'd0; sweep_i = 1'b0; base_i = 32'h40; count_i = 32'd4; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        #1;
        n = 0;
        while (!(rd_o && (rd_starts - rs) >= 2) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rstmid.reached", (n < 200), 1'b1);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("rstmid.outs", {we_o, rd_o, busy_o, done_o, pass_o, err_count_o}, 7'd0);
        chk("rstmid.addr_data", {addr_o, data_o}, 64'h0);
        chk("rstmid.state", state_o, 16'h0);
        @(negedge clk); rstn = 1'b1; force_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("late_ack.outs", {we_o, rd_o, busy_o, done_o, pass_o}, 5'd0);
        chk("late_ack.state", state_o, 16'h0);
        @(negedge clk); force_ack = 1'b0;

        run_test("cnt0", 2'd0, 1'b0, 32'h80, 32'd0, 0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        run_test("addr_il2", 2'd0, 1'b0, 32'h100, 32'd4, 0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        chk("no_overlap", overlap_seen, 1'b0);
        chk("req_stable", unstable_seen, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
